// File: rtl/inst_queue.sv
// Show-ahead circular instruction queue between fetch and issue, holding {inst, pc, pc_next}.
// Optional same-cycle fetch-to-issue bypass on an empty queue is enabled by defining IQ_BYPASS_EN.
module inst_queue #(
    parameter int  DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_valid,
    input  logic [31:0]      fetch_inst,
    input  logic [31:0]      fetch_pc,
    input  logic [31:0]      fetch_pc_next,
    output logic             iq_full,
    input  logic             issue_req,
    output logic             iq_rvalid,
    output logic [31:0]      iq_inst,
    output logic [31:0]      iq_pc,
    output logic [31:0]      iq_pc_next,
    output logic [PTR_W:0]   iq_count,
    input  logic             flush
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [31:0]      inst_mem    [DEPTH];
    logic [31:0]      pc_mem      [DEPTH];
    logic [31:0]      pc_next_mem [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [PTR_W:0]   count;

    logic not_empty;
    logic bypass_take;
    logic push_en;
    logic pop_en;

    // Handshakes: fetch hands over an entry when fetch_valid && !iq_full and holds it otherwise;
    // the issuer takes the head when issue_req && iq_rvalid. flush overrides both.
    assign not_empty = (count != '0);
    assign iq_full   = (count == FULL_COUNT);
    assign iq_count  = count;

`ifdef IQ_BYPASS_EN
    logic bypass;
    assign bypass      = !not_empty && fetch_valid && !flush;
    assign bypass_take = bypass && issue_req;
    assign iq_rvalid   = not_empty || bypass;
    assign iq_inst     = bypass ? fetch_inst    : inst_mem[head_ptr];
    assign iq_pc       = bypass ? fetch_pc      : pc_mem[head_ptr];
    assign iq_pc_next  = bypass ? fetch_pc_next : pc_next_mem[head_ptr];
`else
    assign bypass_take = 1'b0;
    assign iq_rvalid   = not_empty;
    assign iq_inst     = inst_mem[head_ptr];
    assign iq_pc       = pc_mem[head_ptr];
    assign iq_pc_next  = pc_next_mem[head_ptr];
`endif

    // A bypassed instruction is consumed straight from fetch and never occupies a slot.
    assign push_en = fetch_valid && !iq_full && !flush && !bypass_take;
    assign pop_en  = issue_req && not_empty && !flush;

    always_ff @(posedge clk) begin
        if (push_en) begin
            inst_mem[tail_ptr]    <= fetch_inst;
            pc_mem[tail_ptr]      <= fetch_pc;
            pc_next_mem[tail_ptr] <= fetch_pc_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push_en) tail_ptr <= tail_ptr + 1'b1;
            if (pop_en)  head_ptr <= head_ptr + 1'b1;
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifndef SYNTHESIS
    logic [PTR_W-1:0] ptr_diff;
    assign ptr_diff = tail_ptr - head_ptr;

    always @(posedge clk) begin
        if (rst) begin
            assert (count <= FULL_COUNT);
            assert ((count == FULL_COUNT) ? (ptr_diff == '0)
                                          : (!count[PTR_W] && (count[PTR_W-1:0] == ptr_diff)));
        end
    end
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: reset, fill/drain, full-push rejection, wrap, flush,
// asynchronous reset and the empty-queue fetch/issue cycle (both bypass builds).
module tb_inst_queue;

    logic        clk;
    logic        rst;
    logic        fetch_valid;
    logic [31:0] fetch_inst;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_next;
    logic        iq_full;
    logic        issue_req;
    logic        iq_rvalid;
    logic [31:0] iq_inst;
    logic [31:0] iq_pc;
    logic [31:0] iq_pc_next;
    logic [3:0]  iq_count;
    logic        flush;

    int vectors;
    int miscompares;
    logic [31:0] exp_q[$];

    inst_queue #(.DEPTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_valid   (fetch_valid),
        .fetch_inst    (fetch_inst),
        .fetch_pc      (fetch_pc),
        .fetch_pc_next (fetch_pc_next),
        .iq_full       (iq_full),
        .issue_req     (issue_req),
        .iq_rvalid     (iq_rvalid),
        .iq_inst       (iq_inst),
        .iq_pc         (iq_pc),
        .iq_pc_next    (iq_pc_next),
        .iq_count      (iq_count),
        .flush         (flush)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus instruction word tied to the PC; pc 0x60 maps to 0x00000013.
    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return 32'h0000_0013 + ((pc - 32'h60) << 7);
    endfunction

    // driver tasks
    task automatic set_in(input logic fv, input logic [31:0] pc, input logic ireq, input logic fl);
        fetch_valid   = fv;
        fetch_pc      = pc;
        fetch_inst    = inst_of(pc);
        fetch_pc_next = pc + 32'd4;
        issue_req     = ireq;
        flush         = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        #3;
        vectors++;
        if (iq_rvalid !== 1'b0) begin miscompares++; $display("FAIL reset_rvalid: got %b expected 0", iq_rvalid); end
        vectors++;
        if (iq_full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b expected 0", iq_full); end
        vectors++;
        if (iq_count !== 4'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", iq_count); end
        #4;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_push();
        set_in(1'b1, 32'h60, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        vectors++;
        if (iq_rvalid !== 1'b1) begin miscompares++; $display("FAIL single_rvalid: got %b expected 1", iq_rvalid); end
        vectors++;
        if (iq_inst !== 32'h0000_0013) begin miscompares++; $display("FAIL single_inst: got %h expected 00000013", iq_inst); end
        vectors++;
        if (iq_pc !== 32'h60) begin miscompares++; $display("FAIL single_pc: got %h expected 00000060", iq_pc); end
        vectors++;
        if (iq_pc_next !== 32'h64) begin miscompares++; $display("FAIL single_pc_next: got %h expected 00000064", iq_pc_next); end
        vectors++;
        if (iq_count !== 4'd1) begin miscompares++; $display("FAIL single_count: got %0d expected 1", iq_count); end
        tick();
        set_in(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        vectors++;
        if (iq_rvalid !== 1'b0 || iq_count !== 4'd0) begin
            miscompares++;
            $display("FAIL single_pop_empty: got rvalid=%b count=%0d expected 0/0", iq_rvalid, iq_count);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 32'h60 + 32'(4 * i), 1'b0, 1'b0);
            exp_q.push_back(32'h60 + 32'(4 * i));
            tick();
        end
        set_in(1'b1, 32'h80, 1'b0, 1'b0);
        #1;
        vectors++;
        if (iq_full !== 1'b1 || iq_count !== 4'd8) begin
            miscompares++;
            $display("FAIL fill_full: got full=%b count=%0d expected 1/8", iq_full, iq_count);
        end
        tick();
        set_in(1'b1, 32'h80, 1'b1, 1'b0);
        #1;
        vectors++;
        if (iq_count !== 4'd8 || iq_pc !== 32'h60) begin
            miscompares++;
            $display("FAIL fill_ninth_ignored: got count=%0d pc=%h expected 8/00000060", iq_count, iq_pc);
        end
        tick();
        void'(exp_q.pop_front());
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        vectors++;
        if (iq_count !== 4'd7 || iq_full !== 1'b0 || iq_pc !== 32'h64) begin
            miscompares++;
            $display("FAIL full_push_pop: got count=%0d full=%b pc=%h expected 7/0/00000064", iq_count, iq_full, iq_pc);
        end
        for (int i = 0; i < 7; i++) begin
            set_in(1'b0, 32'h0, 1'b1, 1'b0);
            #1;
            vectors++;
            if (iq_rvalid !== 1'b1 || iq_pc !== exp_q[0] || iq_inst !== inst_of(exp_q[0])) begin
                miscompares++;
                $display("FAIL drain_order: got rvalid=%b pc=%h inst=%h expected 1/%h/%h",
                         iq_rvalid, iq_pc, iq_inst, exp_q[0], inst_of(exp_q[0]));
            end
            void'(exp_q.pop_front());
            tick();
        end
        set_in(1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        vectors++;
        if (iq_rvalid !== 1'b0 || iq_count !== 4'd0) begin
            miscompares++;
            $display("FAIL drain_empty: got rvalid=%b count=%0d expected 0/0", iq_rvalid, iq_count);
        end
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        vectors++;
        if (iq_count !== 4'd0) begin miscompares++; $display("FAIL pop_when_empty: got count=%0d expected 0", iq_count); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'b0);
            exp_q.push_back(32'h300 + 32'(4 * i));
            tick();
        end
        for (int c = 0; c < 20; c++) begin
            set_in(1'b1, 32'h314 + 32'(4 * c), 1'b1, 1'b0);
            #1;
            vectors++;
            if (iq_count !== 4'd5 || iq_pc !== exp_q[0] || iq_pc_next !== exp_q[0] + 32'd4) begin
                miscompares++;
                $display("FAIL wrap_stream: got count=%0d pc=%h pc_next=%h expected 5/%h/%h",
                         iq_count, iq_pc, iq_pc_next, exp_q[0], exp_q[0] + 32'd4);
            end
            void'(exp_q.pop_front());
            exp_q.push_back(32'h314 + 32'(4 * c));
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, 32'h0, 1'b1, 1'b0);
            #1;
            vectors++;
            if (iq_pc !== exp_q[0] || iq_count !== 4'(5 - i)) begin
                miscompares++;
                $display("FAIL wrap_drain: got pc=%h count=%0d expected %h/%0d", iq_pc, iq_count, exp_q[0], 5 - i);
            end
            void'(exp_q.pop_front());
            tick();
        end
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        vectors++;
        if (iq_rvalid !== 1'b0) begin miscompares++; $display("FAIL wrap_empty: got rvalid=%b expected 0", iq_rvalid); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 6; i++) begin
            set_in(1'b1, 32'h400 + 32'(4 * i), 1'b0, 1'b0);
            tick();
        end
        set_in(1'b1, 32'h418, 1'b1, 1'b1);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        vectors++;
        if (iq_count !== 4'd0 || iq_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_clear: got count=%0d rvalid=%b expected 0/0", iq_count, iq_rvalid);
        end
        tick();
        set_in(1'b1, 32'h200, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        vectors++;
        if (iq_pc !== 32'h200 || iq_count !== 4'd1) begin
            miscompares++;
            $display("FAIL flush_restart: got pc=%h count=%0d expected 00000200/1", iq_pc, iq_count);
        end
        set_in(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'h500 + 32'(4 * i), 1'b0, 1'b0);
            tick();
        end
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (iq_rvalid !== 1'b0 || iq_count !== 4'd0 || iq_full !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got rvalid=%b count=%0d full=%b expected 0/0/0", iq_rvalid, iq_count, iq_full);
        end
        #1;
        rst = 1'b1;
        tick();
        set_in(1'b1, 32'h40, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        vectors++;
        if (iq_pc !== 32'h40 || iq_count !== 4'd1) begin
            miscompares++;
            $display("FAIL reset_restart: got pc=%h count=%0d expected 00000040/1", iq_pc, iq_count);
        end
        set_in(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_bypass();
        set_in(1'b1, 32'h100, 1'b1, 1'b0);
        #1;
`ifdef IQ_BYPASS_EN
        vectors++;
        if (iq_rvalid !== 1'b1 || iq_pc !== 32'h100 || iq_count !== 4'd0) begin
            miscompares++;
            $display("FAIL bypass_same_cycle: got rvalid=%b pc=%h count=%0d expected 1/00000100/0", iq_rvalid, iq_pc, iq_count);
        end
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        vectors++;
        if (iq_rvalid !== 1'b0 || iq_count !== 4'd0) begin
            miscompares++;
            $display("FAIL bypass_consumed: got rvalid=%b count=%0d expected 0/0", iq_rvalid, iq_count);
        end
`else
        vectors++;
        if (iq_rvalid !== 1'b0) begin miscompares++; $display("FAIL nobypass_same_cycle: got rvalid=%b expected 0", iq_rvalid); end
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        vectors++;
        if (iq_rvalid !== 1'b1 || iq_count !== 4'd1 || iq_pc !== 32'h100) begin
            miscompares++;
            $display("FAIL nobypass_next_cycle: got rvalid=%b count=%0d pc=%h expected 1/1/00000100", iq_rvalid, iq_count, iq_pc);
        end
`endif
        set_in(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single_push();
        test_fill_drain();
        test_wrap();
        test_flush();
        test_async_reset();
        test_bypass();
        // final report
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
